spi_master_out: RTL and testbench

// - Write-only SPI master for a serial DAC, inside the measure unit's dac_spi block.
// - Takes one DATA_WIDTH-bit word per handshake and frames it with active-low sync.
// - Shifts it out MSB-first on mosi with a divided sclk.
// - No MISO; rdy tells the controller when the next word can be written.

---
 rtl/spi_master_out.sv | 131 +++++++++++++
 tb/tb_spi_master_out.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_out.sv
// Write-only SPI master for a serial DAC: frames one word with active-low sync and shifts it out on mosi under a divided sclk.
// Define SPI_MASTER_O_LSB_FIRST_EN to shift LSB first; by default the word goes out MSB first.
module spi_master_out #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wre_i,
  output logic                  rdy,
  output logic                  mosi,
  output logic                  sclk,
  output logic                  sync
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
`ifdef SPI_MASTER_O_LSB_FIRST_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = DATA_WIDTH - 1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d, shifted;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic [PW-1:0]         phase_cnt, phase_cnt_d;
  logic                  rdy_d, mosi_d, sclk_d, sync_d;
  logic                  phase_end;

  assign phase_end = (phase_cnt == PH_LAST);

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      rdy       <= 1'b1;
      sync      <= 1'b1;
      sclk      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      phase_cnt <= phase_cnt_d;
      rdy       <= rdy_d;
      sync      <= sync_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
    end
  end

  // Every output is computed here one cycle ahead and registered, so no input reaches a pin combinationally.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    phase_cnt_d = phase_cnt;
    rdy_d       = rdy;
    sync_d      = sync;
    sclk_d      = sclk;
    mosi_d      = mosi;
`ifdef SPI_MASTER_O_LSB_FIRST_EN
    shifted     = shreg >> 1;
`else
    shifted     = shreg << 1;
`endif
    case (state)
      IDLE: begin
        if (wre_i) begin
          shreg_d     = data_i;
          bit_cnt_d   = '0;
          phase_cnt_d = '0;
          rdy_d       = 1'b0;
          sync_d      = 1'b0;
          sclk_d      = 1'b1;
          mosi_d      = data_i[FIRST];
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          if (sclk) begin
            sclk_d = 1'b0;
          end else begin
            // mosi only moves on the rising edge, keeping it stable across the DAC's falling-edge sample.
            sclk_d = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_d = TRAIL;
            end else begin
              bit_cnt_d = bit_cnt + 1'b1;
              shreg_d   = shifted;
              mosi_d    = shifted[FIRST];
            end
          end
        end else begin
          phase_cnt_d = phase_cnt + 1'b1;
        end
      end
      TRAIL: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          sync_d      = 1'b1;
          mosi_d      = 1'b0;
          state_d     = GAP;
        end else begin
          phase_cnt_d = phase_cnt + 1'b1;
        end
      end
      GAP: begin
        if (phase_end) begin
          phase_cnt_d = '0;
          rdy_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          phase_cnt_d = phase_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_out.sv
// Self-checking bench for spi_master_out: captures mosi at each falling sclk and compares against a word-level model.
// Honours SPI_MASTER_O_LSB_FIRST_EN the same way the design does.
module tb_spi_master_out;

  localparam int DW         = 8;
  localparam int CD         = 2;
  localparam int BUSY       = (2 * DW + 2) * CD;
  localparam int SYNC_LOW_N = (2 * DW + 1) * CD;

  logic          clk;
  logic          arst_i;
  logic [DW-1:0] data_i;
  logic          wre_i;
  logic          rdy, mosi, sclk, sync;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] cap_word;
  int            cap_falls, cap_busy, cap_sync_err, cap_stab_err, cap_sync_high;
  bit            cap_timeout;

  spi_master_out #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk_i (clk),
    .arst_i(arst_i),
    .data_i(data_i),
    .wre_i (wre_i),
    .rdy   (rdy),
    .mosi  (mosi),
    .sclk  (sclk),
    .sync  (sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The word as the DAC assembles it, oldest sampled bit in the MSB.
  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] d);
    logic [DW-1:0] r;
`ifdef SPI_MASTER_O_LSB_FIRST_EN
    for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
`else
    r = d;
`endif
    return r;
  endfunction

  // Called just after wre_i was raised at a negedge; n counts negedges after the accept edge.
  task automatic capture_frame(input bit hold_wre, input logic [DW-1:0] next_data, input int pulse_at);
    logic prev_sclk, prev_mosi;
    cap_word = '0; cap_falls = 0; cap_busy = 0; cap_sync_err = 0;
    cap_stab_err = 0; cap_sync_high = 0; cap_timeout = 1;
    prev_sclk = 1'b1; prev_mosi = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (sclk === 1'b0 && prev_sclk === 1'b1) begin
        cap_falls++;
        cap_word = {cap_word[DW-2:0], mosi};
        if (mosi !== prev_mosi) cap_stab_err++;
      end
      if (sync !== ((n <= SYNC_LOW_N) ? 1'b0 : 1'b1)) cap_sync_err++;
      if (sync === 1'b1) cap_sync_high++;
      if (hold_wre) begin
        if (n == 1) data_i = next_data;
      end else if (n == pulse_at) begin
        wre_i = 1'b1; data_i = 8'h55;
      end else begin
        wre_i = 1'b0;
      end
      if (rdy === 1'b1) begin
        cap_busy = n - 1; cap_timeout = 0;
        break;
      end
      prev_sclk = sclk; prev_mosi = mosi;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); arst_i = 1'b1; wre_i = 1'b0;
    @(negedge clk); arst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({rdy, sync, sclk, mosi} !== 4'b1110) begin
        bad++; $display("[TB] FAIL reset_idle cycle %0d: got %b want 1110", i, {rdy, sync, sclk, mosi});
      end
    end
    @(negedge clk); arst_i = 1'b1; wre_i = 1'b1; data_i = 8'hFF;
    @(negedge clk); arst_i = 1'b0; wre_i = 1'b0;
    total++;
    if ({rdy, sync} !== 2'b11) begin
      bad++; $display("[TB] FAIL reset_wins: got rdy,sync=%b want 11", {rdy, sync});
    end
  endtask

  task automatic test_single_frame();
    @(negedge clk); data_i = 8'hAA; wre_i = 1'b1;
    capture_frame(0, '0, 10);
    total++;
    if (cap_timeout !== 0) begin bad++; $display("[TB] FAIL single_timeout: rdy never returned"); end
    total++;
    if (cap_word !== model_word(8'hAA)) begin
      bad++; $display("[TB] FAIL single_word: got %h want %h", cap_word, model_word(8'hAA));
    end
    total++;
    if (cap_falls !== DW) begin bad++; $display("[TB] FAIL single_falls: got %0d want %0d", cap_falls, DW); end
    total++;
    if (cap_busy !== BUSY) begin bad++; $display("[TB] FAIL single_busy: got %0d want %0d", cap_busy, BUSY); end
    total++;
    if (cap_sync_err !== 0) begin bad++; $display("[TB] FAIL single_sync: %0d bad cycles want 0", cap_sync_err); end
    total++;
    if (cap_stab_err !== 0) begin bad++; $display("[TB] FAIL single_mosi_stable: %0d changes want 0", cap_stab_err); end
    // The wre_i pulse sent mid-frame must not leave a queued second frame behind.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rdy, sync} !== 2'b11) begin
        bad++; $display("[TB] FAIL busy_ignore cycle %0d: got rdy,sync=%b want 11", i, {rdy, sync});
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); data_i = 8'h0F; wre_i = 1'b1;
    capture_frame(1, 8'hF0, 0);
    total++;
    if (cap_word !== model_word(8'h0F)) begin
      bad++; $display("[TB] FAIL b2b_first: got %h want %h", cap_word, model_word(8'h0F));
    end
    total++;
    if (cap_sync_high < CD) begin
      bad++; $display("[TB] FAIL b2b_gap: sync high %0d cycles want >= %0d", cap_sync_high, CD);
    end
    capture_frame(0, '0, 0);
    total++;
    if (cap_timeout !== 0 || cap_word !== model_word(8'hF0)) begin
      bad++; $display("[TB] FAIL b2b_second: got %h timeout %0d want %h", cap_word, cap_timeout, model_word(8'hF0));
    end
    total++;
    if (cap_busy !== BUSY) begin bad++; $display("[TB] FAIL b2b_busy: got %0d want %0d", cap_busy, BUSY); end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    int   falls;
    logic prev_sclk;
    falls = 0; prev_sclk = 1'b1;
    @(negedge clk); data_i = 8'hC3; wre_i = 1'b1;
    for (int n = 0; n < 200 && falls < 3; n++) begin
      @(negedge clk); wre_i = 1'b0;
      if (sclk === 1'b0 && prev_sclk === 1'b1) falls++;
      prev_sclk = sclk;
    end
    total++;
    if (falls !== 3) begin bad++; $display("[TB] FAIL midreset_falls: got %0d want 3", falls); end
    arst_i = 1'b1;
    @(negedge clk); arst_i = 1'b0;
    total++;
    if ({rdy, sync, sclk, mosi} !== 4'b1110) begin
      bad++; $display("[TB] FAIL midreset_abort: got %b want 1110", {rdy, sync, sclk, mosi});
    end
    d = DW'($urandom);
    @(negedge clk); data_i = d; wre_i = 1'b1;
    capture_frame(0, '0, 0);
    total++;
    if (cap_word !== model_word(d) || cap_busy !== BUSY) begin
      bad++; $display("[TB] FAIL midreset_next: got %h busy %0d want %h busy %0d", cap_word, cap_busy, model_word(d), BUSY);
    end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    for (int f = 0; f < 8; f++) begin
      d = DW'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(negedge clk); data_i = d; wre_i = 1'b1;
      capture_frame(0, '0, $urandom_range(2, 30));
      total++;
      if (cap_timeout !== 0 || cap_word !== model_word(d)) begin
        bad++; $display("[TB] FAIL rand_word %0d: got %h timeout %0d want %h", f, cap_word, cap_timeout, model_word(d));
      end
      total++;
      if (cap_falls !== DW || cap_busy !== BUSY) begin
        bad++; $display("[TB] FAIL rand_timing %0d: falls %0d busy %0d want %0d %0d", f, cap_falls, cap_busy, DW, BUSY);
      end
      total++;
      if (cap_sync_err !== 0 || cap_stab_err !== 0) begin
        bad++; $display("[TB] FAIL rand_sync_mosi %0d: sync err %0d mosi err %0d want 0 0", f, cap_sync_err, cap_stab_err);
      end
    end
  endtask

  initial begin
    arst_i = 1'b1; wre_i = 1'b0; data_i = '0;
    repeat (2) @(negedge clk);
    arst_i = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_mid_reset();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
